fifo_axis_source: RTL and testbench

//  Downstream drain stage for the synchronous stream FIFO. Pops words over the FIFO read port
//  and re-emits them as an AXI-Stream master with packet framing (m_tlast every PKT_LEN beats).
//  A 3-entry output buffer hides the FIFO's 1-cycle read latency and sustains 1 beat/cycle.

---
 rtl/fifo_axis_source_pkg.sv | 22 ++
 rtl/axis_obuf3.sv | 48 ++++
 rtl/fifo_axis_source.sv | 74 +++++++
 tb/tb_fifo_axis_source.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/fifo_axis_source_pkg.sv
// Shared defaults, types and helpers for the FIFO-to-AXI-Stream drain stage.
// Producer, FIFO and drain stage take their default data and counter widths from here.
package fifo_axis_source_pkg;

    localparam int AXIS_DWIDTH  = 32;
    localparam int AXIS_PKT_LEN = 8;
    localparam int AXIS_CNT_W   = 16;
    localparam int OBUF_DEPTH   = 3;

    typedef logic [1:0] obuf_ptr_t;
    typedef logic [1:0] obuf_cnt_t;

    // Beat counter needs at least one bit so PKT_LEN=1 still yields a legal vector.
    function automatic int beat_cnt_width(input int pkt_len);
        return (pkt_len > 1) ? $clog2(pkt_len) : 1;
    endfunction

    function automatic obuf_ptr_t obuf_ptr_next(input obuf_ptr_t ptr);
        return (ptr == obuf_ptr_t'(OBUF_DEPTH - 1)) ? '0 : ptr + obuf_ptr_t'(1);
    endfunction

endpackage

// File: rtl/axis_obuf3.sv
// Three-entry circular output buffer; the head entry is read straight from storage
// registers so the stream data never sees logic after the flops beyond the head mux.
module axis_obuf3
    import fifo_axis_source_pkg::*;
#(
    parameter int DWIDTH = AXIS_DWIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr,
    input  logic [DWIDTH-1:0] wr_data,
    input  logic              rd,
    output obuf_cnt_t         count,
    output logic [DWIDTH-1:0] head_data
);

    logic [DWIDTH-1:0] mem [OBUF_DEPTH];
    obuf_ptr_t         wr_ptr;
    obuf_ptr_t         rd_ptr;

    // Simultaneous write and read advance both pointers and leave the count alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < OBUF_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= obuf_ptr_next(wr_ptr);
            end
            if (rd) begin
                rd_ptr <= obuf_ptr_next(rd_ptr);
            end
            if (wr && !rd) begin
                count <= count + obuf_cnt_t'(1);
            end else if (rd && !wr) begin
                count <= count - obuf_cnt_t'(1);
            end
        end
    end

    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/fifo_axis_source.sv
// Drains the stream FIFO into an AXI-Stream master with PKT_LEN-beat packet framing,
// hiding the FIFO read latency behind a three-entry output buffer.
module fifo_axis_source
    import fifo_axis_source_pkg::*;
#(
    parameter int DWIDTH  = AXIS_DWIDTH,
    parameter int PKT_LEN = AXIS_PKT_LEN,
    parameter int CNT_W   = AXIS_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    input  logic [DWIDTH-1:0] fifo_dout,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic [DWIDTH-1:0] m_tdata,
    output logic              m_tlast,
    output logic [CNT_W-1:0]  pkt_count
);

    localparam int            BW        = beat_cnt_width(PKT_LEN);
    localparam logic [BW-1:0] LAST_BEAT = BW'(PKT_LEN - 1);

    logic          pending;
    obuf_cnt_t     count;
    logic [2:0]    committed;
    logic          xfer;
    logic [BW-1:0] beat_cnt;

    // Buffered plus in-flight words must stay within the three slots, so a pop is only
    // issued when its word is guaranteed a home; rst_n keeps the FIFO untouched in reset.
    assign committed  = {1'b0, count} + {2'b00, pending};
    assign fifo_rd_en = rst_n && !fifo_empty && (committed < 3'd3);

    assign m_tvalid = (count != '0);
    assign m_tlast  = m_tvalid && (beat_cnt == LAST_BEAT);
    assign xfer     = m_tvalid && m_tready;

    axis_obuf3 #(
        .DWIDTH(DWIDTH)
    ) u_obuf (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr       (pending),
        .wr_data  (fifo_dout),
        .rd       (xfer),
        .count    (count),
        .head_data(m_tdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= 1'b0;
        end else begin
            pending <= fifo_rd_en;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt  <= '0;
            pkt_count <= '0;
        end else if (xfer) begin
            if (beat_cnt == LAST_BEAT) begin
                beat_cnt  <= '0;
                pkt_count <= pkt_count + CNT_W'(1);
            end else begin
                beat_cnt <= beat_cnt + BW'(1);
            end
        end
    end

endmodule

// File: tb/tb_fifo_axis_source.sv
// Randomised bench for fifo_axis_source: a queue-based FIFO and stream model drive two
// instances (8-beat packets with a 4-bit packet counter, and 1-beat packets).
module tb_fifo_axis_source;

    localparam int DW     = 32;
    localparam int PKT_A  = 8;
    localparam int CNTW_A = 4;
    localparam int PKT_B  = 1;
    localparam int CNTW_B = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              fifo_empty = 1'b1;
    logic [DW-1:0]     fifo_dout = '0;
    logic              m_tready = 1'b0;

    logic              rd_en_a, tvalid_a, tlast_a;
    logic [DW-1:0]     tdata_a;
    logic [CNTW_A-1:0] pkt_a;
    logic              rd_en_b, tvalid_b, tlast_b;
    logic [DW-1:0]     tdata_b;
    logic [CNTW_B-1:0] pkt_b;

    fifo_axis_source #(.DWIDTH(DW), .PKT_LEN(PKT_A), .CNT_W(CNTW_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_rd_en(rd_en_a),
        .fifo_dout(fifo_dout), .m_tvalid(tvalid_a), .m_tready(m_tready),
        .m_tdata(tdata_a), .m_tlast(tlast_a), .pkt_count(pkt_a)
    );

    fifo_axis_source #(.DWIDTH(DW), .PKT_LEN(PKT_B), .CNT_W(CNTW_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_rd_en(rd_en_b),
        .fifo_dout(fifo_dout), .m_tvalid(tvalid_b), .m_tready(m_tready),
        .m_tdata(tdata_b), .m_tlast(tlast_b), .pkt_count(pkt_b)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] fifo_q [$];
    logic [DW-1:0] obuf [$];
    logic [DW-1:0] next_dout = '0;
    bit            m_pending = 1'b0;
    int            beats = 0;
    int            pops_seen = 0;
    int            n_checks = 0;
    int            n_fail = 0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic checkReset();
        checkOutput("rst_tvalid_a", 32'(tvalid_a), 32'(0));
        checkOutput("rst_tvalid_b", 32'(tvalid_b), 32'(0));
        checkOutput("rst_tlast_a", 32'(tlast_a), 32'(0));
        checkOutput("rst_tlast_b", 32'(tlast_b), 32'(0));
        checkOutput("rst_tdata_a", tdata_a, 32'(0));
        checkOutput("rst_tdata_b", tdata_b, 32'(0));
        checkOutput("rst_rd_en_a", 32'(rd_en_a), 32'(0));
        checkOutput("rst_rd_en_b", 32'(rd_en_b), 32'(0));
        checkOutput("rst_pkt_a", 32'(pkt_a), 32'(0));
        checkOutput("rst_pkt_b", 32'(pkt_b), 32'(0));
    endtask

    // One clock cycle, entered and left at a falling edge: drive, check, then advance the model.
    task automatic applyStimulus(input bit rdy, input int refill_max);
        bit exp_valid;
        bit exp_rd;
        fifo_dout = next_dout;
        m_tready  = rdy;
        if (refill_max > 0 && fifo_q.size() < 8 && $urandom_range(0, 1) == 1) begin
            repeat ($urandom_range(1, refill_max)) fifo_q.push_back($urandom);
        end
        fifo_empty = (fifo_q.size() == 0);
        #1;
        exp_valid = (obuf.size() != 0);
        exp_rd    = (fifo_q.size() != 0) && (obuf.size() + int'(m_pending) < 3);
        checkOutput("rd_en_a", 32'(rd_en_a), 32'(exp_rd));
        checkOutput("rd_en_b", 32'(rd_en_b), 32'(exp_rd));
        checkOutput("tvalid_a", 32'(tvalid_a), 32'(exp_valid));
        checkOutput("tvalid_b", 32'(tvalid_b), 32'(exp_valid));
        if (exp_valid) begin
            checkOutput("tdata_a", tdata_a, obuf[0]);
            checkOutput("tdata_b", tdata_b, obuf[0]);
        end
        checkOutput("tlast_a", 32'(tlast_a), 32'(exp_valid && (beats % PKT_A == PKT_A - 1)));
        checkOutput("tlast_b", 32'(tlast_b), 32'(exp_valid));
        checkOutput("pkt_a", 32'(pkt_a), (beats / PKT_A) % (1 << CNTW_A));
        checkOutput("pkt_b", 32'(pkt_b), (beats / PKT_B) % (1 << CNTW_B));
        if (exp_valid && rdy) begin
            void'(obuf.pop_front());
            beats++;
        end
        if (m_pending) obuf.push_back(fifo_dout);
        m_pending = exp_rd;
        if (exp_rd) begin
            next_dout = fifo_q.pop_front();
            pops_seen++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Asynchronous reset asserted between clock edges; buffered and in-flight words are lost.
    task automatic applyReset();
        #2 rst_n = 1'b0;
        #1 checkReset();
        obuf.delete();
        m_pending = 1'b0;
        beats     = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bit reached;
        for (int i = 0; i < 16; i++) fifo_q.push_back(32'(i));
        fifo_empty = 1'b0;
        repeat (2) @(negedge clk);
        #1 checkReset();
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] preloaded 0..15 at full rate");
        repeat (22) applyStimulus(1'b1, 0);
        checkOutput("pkt_after16_a", 32'(pkt_a), 32'(2));
        checkOutput("pkt_after16_b", 32'(pkt_b), 32'(16));

        $display("[TB] back-pressure stall");
        for (int i = 0; i < 10; i++) fifo_q.push_back(32'(100 + i));
        pops_seen = 0;
        repeat (8) applyStimulus(1'b0, 0);
        checkOutput("stall_pops", 32'(pops_seen), 32'(3));
        repeat (16) applyStimulus(1'b1, 0);

        $display("[TB] reset with two buffered words and one in flight");
        for (int i = 0; i < 14; i++) fifo_q.push_back(32'(200 + i));
        reached = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (obuf.size() == 2 && m_pending) begin
                reached = 1'b1;
                break;
            end
            applyStimulus(1'b0, 0);
        end
        checkOutput("reach_cnt2_pend", 32'(reached), 32'(1));
        applyReset();
        repeat (20) applyStimulus(1'b1, 0);

        $display("[TB] random ready and refill");
        repeat (400) applyStimulus($urandom_range(0, 1) == 1, 3);
        repeat (12) applyStimulus(1'b1, 0);

        $display("[TB] 17 packets for counter wrap");
        for (int i = 0; i < 17 * PKT_A; i++) fifo_q.push_back($urandom);
        applyReset();
        repeat (17 * PKT_A + 4) applyStimulus(1'b1, 0);
        checkOutput("pkt_wrap_a", 32'(pkt_a), 32'(1));
        checkOutput("pkt_beats_b", 32'(pkt_b), 32'(17 * PKT_A));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
